load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access unit for the RISC-V core.
- Sits directly upstream of the write-back selector and drives its load-data input (selector code 1).
- Converts one load/store per instruction into a request/grant/response bus transaction, with byte-lane alignment, sign/zero extension and a core stall.
- Detects misaligned, illegal and timed-out accesses.

Parameters:
NBits, 32, data and address width; only 32 is supported.
TimeoutCycles, 255, maximum cycles spent in REQ or WAIT_R before an access is aborted; range 1..1023.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
Mem_Read_i  input  1  current instruction is a load
Mem_Write_i  input  1  current instruction is a store
Funct3_i  input  3  instr[14:12], access size/sign
Address_i  input  NBits  effective byte address from the ALU
Write_Data_i  input  NBits  rs2 store data
Load_Data_o  output  NBits  extended load result, to write-back selector
Stall_o  output  1  hold PC and register-file write enable
Access_Fault_o  output  1  one-cycle pulse on misaligned, illegal or timeout
Bus_Req_o  output  1  bus request
Bus_We_o  output  1  1 = write
Bus_Addr_o  output  NBits  word address, {Address_i[31:2],2'b00}
Bus_Wdata_o  output  NBits  lane-replicated store data
Bus_Be_o  output  4  byte enables
Bus_Gnt_i  input  1  request accepted this cycle
Bus_Rvalid_i  input  1  read data valid this cycle
Bus_Rdata_i  input  NBits  read data word

Behaviour:
- Reset (low, asynchronous):
  - State IDLE; all outputs 0, including Load_Data_o, Bus_Req_o and the timeout counter.
  - Asserting reset mid-transaction drops Bus_Req_o immediately; any late Bus_Gnt_i or Bus_Rvalid_i is ignored.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- Access decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- An access is invalid if any of the following holds:
  - Any other Funct3_i code.
  - Mem_Read_i and Mem_Write_i are both high.
  - Halfword with Address_i[0] = 1.
  - Word with Address_i[1:0] != 0.
- IDLE with a valid access:
  - Stall_o = 1, combinationally in the same cycle.
  - Next state REQ; capture Address_i[1:0], Funct3_i and We.
- IDLE with an invalid access:
  - No bus activity; Stall_o = 0.
  - Access_Fault_o = 1 combinationally for that cycle.
  - Load_Data_o is cleared to 0 at the clock edge if the access was a read.
- REQ:
  - Drives Bus_Req_o = 1, Bus_Addr_o, Bus_We_o, Bus_Be_o and Bus_Wdata_o, all registered and held stable until grant.
  - On Bus_Gnt_i: store goes to DONE, load goes to WAIT_R, and Bus_Req_o deasserts next cycle.
- WAIT_R: on Bus_Rvalid_i, register the extended data into Load_Data_o and go to DONE.
  - Bus_Rvalid_i is never sampled in the grant cycle; the earliest response is one cycle after grant.
- DONE:
  - Stall_o = 0; the instruction retires this cycle and the write-back selector sees the new Load_Data_o.
  - Next state IDLE unconditionally.
  - A new access is therefore never started in DONE; back-to-back memory instructions cost at least 3 cycles each (IDLE, REQ, DONE), loads at least 4.
- Stall_o = 1 in IDLE-with-valid-access, REQ and WAIT_R; 0 otherwise.
- Store lanes (o = Address_i[1:0]):
  - SB: Bus_Wdata_o = {4{wd[7:0]}}, Bus_Be_o = 4'b0001<<o.
  - SH: Bus_Wdata_o = {2{wd[15:0]}}, Bus_Be_o = 4'b0011<<o.
  - SW: Bus_Wdata_o = wd, Bus_Be_o = 4'b1111.
- Loads: Bus_Be_o per the same rule.
  - Extraction: d = Bus_Rdata_i >> (8*o).
  - LB/LH sign-extend d[7:0] / d[15:0]; LBU/LHU zero-extend; LW passes d unchanged.
- Load_Data_o:
  - Changes only on load completion, an invalid load or a timed-out load.
  - Holds its value across stores and idle cycles.
- Timeout:
  - The counter clears on entry to REQ and counts every cycle in REQ or WAIT_R.
  - On reaching TimeoutCycles without the awaited event:
    - Pulse Access_Fault_o.
    - Drop Bus_Req_o.
    - Clear Load_Data_o if the access was a load.
    - Go to DONE.
  - If the awaited event arrives in the same cycle the counter reaches TimeoutCycles, the event wins and no fault is raised.
- Inputs Mem_*, Funct3_i, Address_i and Write_Data_i are held stable by the core while Stall_o = 1; the unit uses its captured copies after IDLE.

Test Plan:
- LW at 0x100, Gnt one cycle after Req, Rvalid one cycle later with 0xDEADBEEF -> Load_Data_o = 0xDEADBEEF in DONE; Stall_o high for exactly 3 cycles.
- LB at 0x103 with Rdata 0x80FF_1234 -> Load_Data_o = 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SB at 0x201 with wd 0x000000AB -> Bus_Be_o = 4'b0010, Bus_Wdata_o = 0xABABABAB, Bus_Addr_o = 0x200, Bus_We_o = 1; Load_Data_o unchanged.
- LH at 0x101 or SW at 0x102 -> Access_Fault_o for 1 cycle, Bus_Req_o never asserts, Stall_o = 0, Load_Data_o = 0 for the LH case.
- Load with Bus_Gnt_i held low, TimeoutCycles = 4 -> fault pulse after 4 REQ cycles, Load_Data_o = 0, FSM back in IDLE two cycles later.
- reset pulled low while in WAIT_R, then released, then a late Rvalid with 0x12345678 -> all outputs 0, Load_Data_o stays 0, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request/grant handshake followed by a separate read-response beat.
interface load_store_unit_if #(parameter int NBits = 32);
  logic             Bus_Req_o;
  logic             Bus_We_o;
  logic [NBits-1:0] Bus_Addr_o;
  logic [NBits-1:0] Bus_Wdata_o;
  logic [3:0]       Bus_Be_o;
  logic             Bus_Gnt_i;
  logic             Bus_Rvalid_i;
  logic [NBits-1:0] Bus_Rdata_i;

  modport master (
    output Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o,
    input  Bus_Gnt_i, Bus_Rvalid_i, Bus_Rdata_i
  );
  modport slave (
    input  Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o,
    output Bus_Gnt_i, Bus_Rvalid_i, Bus_Rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per memory instruction, with byte-lane
// steering, load extension, core stall and misaligned/illegal/timeout faults.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  output logic        be_o,
  output logic [7:0]  wbyte_o
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be_o    = 1'b1;
    wbyte_o = wd_i[8*LANE +: 8];
    case (size_i)
      2'b00: begin
        be_o    = (off_i == L);
        wbyte_o = wd_i[7:0];
      end
      2'b01: begin
        // halfwords are already known to be 2-byte aligned here
        be_o    = (off_i[1] == L[1]);
        wbyte_o = wd_i[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int NBits         = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Mem_Read_i,
  input  logic             Mem_Write_i,
  input  logic [2:0]       Funct3_i,
  input  logic [NBits-1:0] Address_i,
  input  logic [NBits-1:0] Write_Data_i,
  output logic [NBits-1:0] Load_Data_o,
  output logic             Stall_o,
  output logic             Access_Fault_o,
  load_store_unit_if.master bus
);
  localparam int NUM_LANES = NBits / 8;
  localparam logic [9:0] TMO_LAST = 10'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  state_e state_q, state_d;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             we_q, req_q, req_d;
  logic [NBits-1:0] addr_q, wdata_q, ld_q, ld_d;
  logic [3:0]       be_q;
  logic [9:0]       cnt_q, cnt_d;

  logic                          acc, code_ok, align_ok, valid, cap, stall, fault, tmo;
  logic [NUM_LANES-1:0]          be_c;
  logic [NUM_LANES-1:0][7:0]     wdata_c;
  logic [NBits-1:0]              rd_shift, ext;

  assign acc = Mem_Read_i | Mem_Write_i;
  always_comb begin
    code_ok = 1'b0;
    case (Funct3_i)
      3'b000, 3'b001, 3'b010: code_ok = 1'b1;
      3'b100, 3'b101:         code_ok = Mem_Read_i;
      default:                code_ok = 1'b0;
    endcase
    align_ok = 1'b1;
    if (Funct3_i[1:0] == 2'b01) align_ok = ~Address_i[0];
    if (Funct3_i[1:0] == 2'b10) align_ok = (Address_i[1:0] == 2'b00);
  end
  assign valid = (Mem_Read_i ^ Mem_Write_i) & code_ok & align_ok;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .size_i  (Funct3_i[1:0]),
      .off_i   (Address_i[1:0]),
      .wd_i    (Write_Data_i),
      .be_o    (be_c[i]),
      .wbyte_o (wdata_c[i])
    );
  end

  assign rd_shift = bus.Bus_Rdata_i >> {off_q, 3'b000};
  always_comb begin
    ext = rd_shift;
    case (f3_q)
      3'b000:  ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ext = {24'b0, rd_shift[7:0]};
      3'b101:  ext = {16'b0, rd_shift[15:0]};
      default: ext = rd_shift;
    endcase
  end

  assign tmo = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          stall   = 1'b1;
          cap     = 1'b1;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end else if (acc) begin
          fault = 1'b1;
          if (Mem_Read_i) ld_d = '0;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 10'd1;
        // the awaited event takes priority over an expiring counter
        if (bus.Bus_Gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT_R;
        end else if (tmo) begin
          fault   = 1'b1;
          req_d   = 1'b0;
          if (!we_q) ld_d = '0;
          state_d = DONE;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        cnt_d = cnt_q + 10'd1;
        if (bus.Bus_Rvalid_i) begin
          ld_d    = ext;
          state_d = DONE;
        end else if (tmo) begin
          fault   = 1'b1;
          ld_d    = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        we_q    <= Mem_Write_i;
        off_q   <= Address_i[1:0];
        f3_q    <= Funct3_i;
        addr_q  <= {Address_i[NBits-1:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
      end
    end
  end

  // combinational outputs are forced low while reset is held
  assign Stall_o          = reset & stall;
  assign Access_Fault_o   = reset & fault;
  assign Load_Data_o      = ld_q;
  assign bus.Bus_Req_o    = req_q;
  assign bus.Bus_We_o     = we_q;
  assign bus.Bus_Addr_o   = addr_q;
  assign bus.Bus_Wdata_o  = wdata_q;
  assign bus.Bus_Be_o     = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; the initial block plays both core and
// memory, with expected load data queued at issue and checked at retirement.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Mem_Read_i = 1'b0, Mem_Write_i = 1'b0;
  logic [2:0]  Funct3_i = 3'b0;
  logic [31:0] Address_i = 32'h0, Write_Data_i = 32'h0;
  logic [31:0] Load_Data_o;
  logic        Stall_o, Access_Fault_o;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] sb_q[$];
  logic [31:0] ld_model = 32'h0;

  always #5 clk = ~clk;

  load_store_unit_if #(.NBits(32)) bus ();

  load_store_unit #(.NBits(32), .TimeoutCycles(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .Mem_Read_i     (Mem_Read_i),
    .Mem_Write_i    (Mem_Write_i),
    .Funct3_i       (Funct3_i),
    .Address_i      (Address_i),
    .Write_Data_i   (Write_Data_i),
    .Load_Data_o    (Load_Data_o),
    .Stall_o        (Stall_o),
    .Access_Fault_o (Access_Fault_o),
    .bus            (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Funct3_i = 3'b0;
    Address_i = 32'h0; Write_Data_i = 32'h0;
    bus.Bus_Gnt_i = 1'b0; bus.Bus_Rvalid_i = 1'b0; bus.Bus_Rdata_i = 32'h0;
  endtask

  // Issues one valid access and services the bus until the unit retires it.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int gnt_wait, input logic [31:0] rdata, input logic [31:0] exp_ld,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        output int stalls, output int faults, output int fault_at);
    int   reqcyc = 0;
    logic gprev = 1'b0;
    logic done = 1'b0;
    stalls = 0; faults = 0; fault_at = -1;
    if (rd) ld_model = exp_ld;
    sb_q.push_back(ld_model);
    @(negedge clk);
    Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = wd;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!Stall_o) begin done = 1'b1; break; end
      stalls++;
      bus.Bus_Rvalid_i = rd && gprev;
      bus.Bus_Rdata_i  = (rd && gprev) ? rdata : 32'h0;
      if (bus.Bus_Req_o) begin
        reqcyc++;
        bus.Bus_Gnt_i = (reqcyc > gnt_wait);
        if (bus.Bus_Gnt_i) begin
          chk({tag, " addr"}, bus.Bus_Addr_o, {addr[31:2], 2'b00});
          chk({tag, " be"}, {28'h0, bus.Bus_Be_o}, {28'h0, exp_be});
          chk({tag, " we"}, {31'h0, bus.Bus_We_o}, {31'h0, wr});
          if (wr) chk({tag, " wdata"}, bus.Bus_Wdata_o, exp_wdata);
        end
      end else begin
        bus.Bus_Gnt_i = 1'b0;
      end
      gprev = bus.Bus_Gnt_i;
      #1;
      if (Access_Fault_o) begin faults++; fault_at = stalls; end
      @(negedge clk); #1;
    end
    chk({tag, " retired"}, {31'h0, done}, 32'h1);
    chk({tag, " ld"}, Load_Data_o, sb_q.pop_front());
    chk({tag, " done req"}, {31'h0, bus.Bus_Req_o}, 32'h0);
    chk({tag, " done fault"}, {31'h0, Access_Fault_o}, 32'h0);
    idle_inputs();
  endtask

  task automatic bad(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = 32'h5A5A5A5A;
    #1;
    chk({tag, " fault"}, {31'h0, Access_Fault_o}, 32'h1);
    chk({tag, " stall"}, {31'h0, Stall_o}, 32'h0);
    chk({tag, " req"}, {31'h0, bus.Bus_Req_o}, 32'h0);
    if (rd) ld_model = 32'h0;
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, " fault end"}, {31'h0, Access_Fault_o}, 32'h0);
    chk({tag, " req after"}, {31'h0, bus.Bus_Req_o}, 32'h0);
    chk({tag, " ld"}, Load_Data_o, ld_model);
  endtask

  initial begin
    int st, fl, fa;
    idle_inputs();
    #2 reset = 1'b0;
    #20;
    chk("rst ld", Load_Data_o, 32'h0);
    chk("rst stall", {31'h0, Stall_o}, 32'h0);
    chk("rst fault", {31'h0, Access_Fault_o}, 32'h0);
    chk("rst req", {31'h0, bus.Bus_Req_o}, 32'h0);
    chk("rst we", {31'h0, bus.Bus_We_o}, 32'h0);
    chk("rst addr", bus.Bus_Addr_o, 32'h0);
    chk("rst be", {28'h0, bus.Bus_Be_o}, 32'h0);
    chk("rst wdata", bus.Bus_Wdata_o, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    access("lw100", 1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0, st, fl, fa);
    chk("lw100 stalls", st, 3);
    access("lb103", 1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF1234, 32'hFFFFFF80, 4'b1000, 0, st, fl, fa);
    access("lbu103", 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF1234, 32'h00000080, 4'b1000, 0, st, fl, fa);
    access("lhu102", 1, 0, 3'b101, 32'h102, 0, 0, 32'h80FF1234, 32'h000080FF, 4'b1100, 0, st, fl, fa);
    access("lh102", 1, 0, 3'b001, 32'h102, 0, 0, 32'h80FF1234, 32'hFFFF80FF, 4'b1100, 0, st, fl, fa);
    // grant late, response lands on the last counter cycle: no fault
    access("lw_edge", 1, 0, 3'b010, 32'h104, 0, 2, 32'h13579BDF, 32'h13579BDF, 4'b1111, 0, st, fl, fa);
    chk("lw_edge stalls", st, 5);
    chk("lw_edge faults", fl, 0);
    access("sb201", 0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0, 0, 4'b0010, 32'hABABABAB, st, fl, fa);
    chk("sb201 stalls", st, 2);
    access("sh202", 0, 1, 3'b001, 32'h202, 32'h1234CDEF, 0, 0, 0, 4'b1100, 32'hCDEFCDEF, st, fl, fa);
    access("sw204", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'hCAFEF00D, st, fl, fa);
    access("lb100", 1, 0, 3'b000, 32'h100, 0, 0, 32'h0000007F, 32'h0000007F, 4'b0001, 0, st, fl, fa);

    bad("lh101", 1, 0, 3'b001, 32'h101);
    access("lw_refill", 1, 0, 3'b010, 32'h10C, 0, 0, 32'hA5A5F00F, 32'hA5A5F00F, 4'b1111, 0, st, fl, fa);
    bad("sw102", 0, 1, 3'b010, 32'h102);
    bad("ld011", 1, 0, 3'b011, 32'h100);
    bad("rdwr", 1, 1, 3'b010, 32'h100);
    access("lw_refill2", 1, 0, 3'b010, 32'h110, 0, 0, 32'h600DF00D, 32'h600DF00D, 4'b1111, 0, st, fl, fa);

    access("lw_tmo", 1, 0, 3'b010, 32'h114, 0, 1000, 32'h0, 32'h0, 4'b1111, 0, st, fl, fa);
    chk("lw_tmo stalls", st, 5);
    chk("lw_tmo faults", fl, 1);
    chk("lw_tmo fault_at", fa, 5);
    @(negedge clk); #1;
    chk("lw_tmo idle stall", {31'h0, Stall_o}, 32'h0);
    chk("lw_tmo idle req", {31'h0, bus.Bus_Req_o}, 32'h0);

    access("lw108", 1, 0, 3'b010, 32'h108, 0, 0, 32'h55AA55AA, 32'h55AA55AA, 4'b1111, 0, st, fl, fa);
    @(negedge clk);
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h300;
    @(negedge clk);
    chk("mid req", {31'h0, bus.Bus_Req_o}, 32'h1);
    bus.Bus_Gnt_i = 1'b1;
    @(negedge clk);
    bus.Bus_Gnt_i = 1'b0;
    chk("mid stall", {31'h0, Stall_o}, 32'h1);
    reset = 1'b0;
    idle_inputs();
    #1;
    ld_model = 32'h0;
    chk("mid rst ld", Load_Data_o, 32'h0);
    chk("mid rst stall", {31'h0, Stall_o}, 32'h0);
    chk("mid rst req", {31'h0, bus.Bus_Req_o}, 32'h0);
    chk("mid rst be", {28'h0, bus.Bus_Be_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    bus.Bus_Rvalid_i = 1'b1; bus.Bus_Rdata_i = 32'h12345678;
    @(negedge clk);
    bus.Bus_Rvalid_i = 1'b0; bus.Bus_Rdata_i = 32'h0;
    #1;
    chk("late rvalid ld", Load_Data_o, 32'h0);
    chk("late rvalid stall", {31'h0, Stall_o}, 32'h0);
    chk("late rvalid req", {31'h0, bus.Bus_Req_o}, 32'h0);
    access("lw_post", 1, 0, 3'b010, 32'h10C, 0, 0, 32'hFEEDC0DE, 32'hFEEDC0DE, 4'b1111, 0, st, fl, fa);
    chk("lw_post stalls", st, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
